tic_tac_toe_auto_player: RTL and testbench
==========================================

// Module: tic_tac_toe_auto_player
// PURPOSE
//  Automatic opponent for the tic-tac-toe game engine; the move source that feeds its cell-index input.
//  On request, takes a board snapshot and the side to play. Returns one legal cell index 1..9.
//  Move priority: immediate win, block opponent's win, centre, corners, edges.
//  Multi-cycle sequential scan, one candidate cell per clock, with a valid/ready result handshake.
// PARAMETERS
//  CELLS     9   number of board cells; fixed 3x3, not to be overridden
//  IDX_W     4   width of cell index (1..9, 0 = no move)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  req         in   1   start request; accepted only while busy=0
//  board       in   18  snapshot; cell k at board[2k-1:2k-2]; 00 empty, 01 X, 10 O, 11 illegal
//  side        in   2   mark to play, 01 or 10; the opponent is ~side
//  busy        out  1   high from acceptance until result handshake completes
//  move        out  4   chosen cell 1..9; 0 when no_move=1
//  move_valid  out  1   result valid; held until move_ready
//  move_ready  in   1   consumer accepts result when move_valid & move_ready
//  no_move     out  1   qualifies move_valid: board full, illegal side, or illegal cell code
// BEHAVIOUR
//  Reset: state IDLE. busy=0, move=0, move_valid=0, no_move=0. Internal latches cleared.
//  Reset mid-operation aborts the scan with no result.
//  States: IDLE, SCAN_WIN, SCAN_BLK, PICK, DONE.
//  IDLE: at edge E0 with req=1, latch board and side, set busy=1.
//   If side is not 01/10, or any cell is 11, go to DONE with no_move=1; move_valid is high after E0+1.
//   Otherwise go to SCAN_WIN with k=1.
//  SCAN_WIN: each edge tests cell k. Hit = cell k empty and placing side there completes one of the 8 lines.
//   Hit: move=k, go to DONE. move_valid is high after edge E0+k.
//   No hit at k=9: go to SCAN_BLK with k=1.
//  SCAN_BLK: same test with the opponent mark. A hit at cell k gives move_valid after E0+9+k.
//   No hit at k=9: go to PICK.
//  PICK: one cycle. Take the first empty cell in order 5,1,3,7,9,2,4,6,8.
//   If none is empty: no_move=1, move=0. Either way move_valid is high after E0+19.
//  Lowest k wins: several winning or blocking cells resolve to the lowest index.
//  Win always beats block.
//  DONE: move, move_valid and no_move are held stable.
//   On an edge with move_ready=1: clear move_valid and no_move, set busy=0, return to IDLE.
//   The next req is accepted no earlier than the following edge.
//  req while busy=1 is ignored, not queued. board and side changes after E0 have no effect.
//  move_ready in any state other than DONE is ignored.
//  All outputs are registered. No combinational path from inputs to outputs.
//  Lines: {1,2,3} {4,5,6} {7,8,9} {1,4,7} {2,5,8} {3,6,9} {1,5,9} {3,5,7}.
// STRUCTURE
//  Package tic_tac_toe_pkg holds:
//   - cell codes EMPTY=2'b00, MARK_X=2'b01, MARK_O=2'b10
//   - state encoding
//   - LINES constant table, 8 entries x 3 cell indices
//   - PICK_ORDER table
//  Sub-module tic_tac_toe_line_check, combinational:
//   - inputs: board, cell index, mark
//   - output: completes, = cell empty and both partner cells on some line through it equal mark
//  One instance, shared by SCAN_WIN and SCAN_BLK by muxing the mark.
//  The top level holds the FSM, the k counter, the snapshot registers and the output registers.
// TESTING
//  1 Win. board X at 1,2; O at 4,5; side=X; req at E0 -> move=3, no_move=0, move_valid rises after E0+3.
//  2 Block. board O at 1,5; X at 2; side=X -> no win; block at 9; move=9, move_valid after E0+18.
//  3 Fallback. Empty board, side=O -> move=5 after E0+19.
//     Then X at 5 only, side=O -> move=1.
//  4 Full or illegal. Full board, no line -> no_move=1, move=0 after E0+19.
//     side=2'b11 -> no_move=1 after E0+1.
//  5 Handshake. move_ready held 0 for 5 cycles -> move and move_valid stable.
//     req pulses while busy are ignored.
//     move_ready=1 -> busy=0 the next cycle. A new req is accepted afterwards.
//  6 Reset. Assert rst mid SCAN_BLK, asynchronously between edges -> outputs go to 0 immediately.
//     After release, req with a fresh board gives a correct result.

Source files
------------

// File: rtl/tic_tac_toe_pkg.sv
// Shared definitions for the tic-tac-toe automatic player.
//   - cell codes and sizing constants
//   - FSM state encoding
//   - LINES: the 8 winning lines, each as 3 cell indices (1..9)
//   - PICK_ORDER: fallback preference, centre then corners then edges
//   - helpers to read a cell out of the packed board and to spot illegal codes
package tic_tac_toe_pkg;

  localparam int CELLS = 9;
  localparam int IDX_W = 4;

  localparam logic [1:0] EMPTY   = 2'b00;
  localparam logic [1:0] MARK_X  = 2'b01;
  localparam logic [1:0] MARK_O  = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCAN_WIN = 3'd1,
    S_SCAN_BLK = 3'd2,
    S_PICK     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LINES [0:7][0:2] = '{
    '{4'd1, 4'd2, 4'd3},
    '{4'd4, 4'd5, 4'd6},
    '{4'd7, 4'd8, 4'd9},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd3, 4'd6, 4'd9},
    '{4'd1, 4'd5, 4'd9},
    '{4'd3, 4'd5, 4'd7}
  };

  localparam logic [IDX_W-1:0] PICK_ORDER [0:CELLS-1] = '{
    4'd5, 4'd1, 4'd3, 4'd7, 4'd9, 4'd2, 4'd4, 4'd6, 4'd8
  };

  // Cell k lives at board[2k-1:2k-2]. An index outside 1..9 shifts the
  // whole board out and reads back as EMPTY, which no line ever references.
  function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b,
                                         input logic [IDX_W-1:0]   idx);
    logic [2*CELLS-1:0] sh;
    sh = b >> (5'(idx) * 5'd2 - 5'd2);
    return sh[1:0];
  endfunction

  function automatic logic has_illegal_cell(input logic [2*CELLS-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (b[2*i +: 2] == ILLEGAL) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/tic_tac_toe_line_check.sv
// Combinational test of one candidate cell.
//   board_i     : packed board snapshot (18 bits)
//   idx_i       : candidate cell 1..9
//   mark_i      : mark that would be placed
//   completes_o : candidate is empty and, on some line through it, both
//                 partner cells already hold mark_i
module tic_tac_toe_line_check
  import tic_tac_toe_pkg::*;
(
  input  logic [2*CELLS-1:0] board_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [1:0]         mark_i,
  output logic               completes_o
);

  logic       on_line;
  logic [1:0] n_match;

  always_comb begin
    completes_o = 1'b0;
    on_line     = 1'b0;
    n_match     = 2'd0;
    if (cell_at(board_i, idx_i) == EMPTY) begin
      for (int l = 0; l < 8; l++) begin
        on_line = 1'b0;
        n_match = 2'd0;
        for (int p = 0; p < 3; p++) begin
          if (LINES[l][p] == idx_i) begin
            on_line = 1'b1;
          end else if (cell_at(board_i, LINES[l][p]) == mark_i) begin
            n_match = n_match + 2'd1;
          end
        end
        if (on_line && (n_match == 2'd2)) completes_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tic_tac_toe_auto_player.sv
// Automatic tic-tac-toe opponent. On req (while idle) it snapshots the
// board and side, then scans one cell per clock: first for a winning
// placement, then for a cell that blocks the opponent, then falls back to
// centre / corners / edges. The result is held under a valid/ready
// handshake.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : start request, taken only while busy=0
//   board      : 9 cells x 2 bits, cell k at board[2k-1:2k-2]
//   side       : mark to play (01 X, 10 O)
//   busy       : high from acceptance until the result is taken
//   move       : chosen cell 1..9, 0 when no_move
//   move_valid : result present; stays high until move_ready
//   move_ready : consumer takes the result on move_valid & move_ready
//   no_move    : qualifies the result: full board or illegal input
//
// Handshake: a result transfers on a rising edge where move_valid and
// move_ready are both high; move, no_move and move_valid do not change
// while move_valid is high and move_ready is low.
module tic_tac_toe_auto_player
  import tic_tac_toe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [2*CELLS-1:0]  board,
  input  logic [1:0]          side,
  output logic                busy,
  output logic [IDX_W-1:0]    move,
  output logic                move_valid,
  input  logic                move_ready,
  output logic                no_move
);

  state_t               state_q;
  logic [IDX_W-1:0]     k_q;
  logic [2*CELLS-1:0]   board_q;
  logic [1:0]           side_q;
  logic                 busy_q;
  logic [IDX_W-1:0]     move_q;
  logic                 move_valid_q;
  logic                 no_move_q;

  logic [1:0]           mark_d;
  logic                 hit_d;
  logic [IDX_W-1:0]     pick_d;
  logic                 req_bad_d;

  // The single line checker serves both scans; only the mark differs.
  assign mark_d = (state_q == S_SCAN_BLK) ? ~side_q : side_q;

  tic_tac_toe_line_check u_line_check (
    .board_i     (board_q),
    .idx_i       (k_q),
    .mark_i      (mark_d),
    .completes_o (hit_d)
  );

  // Walk the preference list backwards so the earliest empty entry wins.
  always_comb begin
    pick_d = '0;
    for (int i = CELLS - 1; i >= 0; i--) begin
      if (cell_at(board_q, PICK_ORDER[i]) == EMPTY) pick_d = PICK_ORDER[i];
    end
  end

  assign req_bad_d = !((side == MARK_X) || (side == MARK_O)) ||
                     has_illegal_cell(board);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      board_q      <= '0;
      side_q       <= '0;
      busy_q       <= 1'b0;
      move_q       <= '0;
      move_valid_q <= 1'b0;
      no_move_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            board_q <= board;
            side_q  <= side;
            busy_q  <= 1'b1;
            k_q     <= 4'd1;
            // Bad input goes straight to DONE; the result is raised there
            // one edge later, so it appears on the same cycle as any other
            // single-cycle answer would.
            state_q <= req_bad_d ? S_DONE : S_SCAN_WIN;
          end
        end

        S_SCAN_WIN, S_SCAN_BLK: begin
          if (hit_d) begin
            move_q       <= k_q;
            no_move_q    <= 1'b0;
            move_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end else if (k_q == 4'd9) begin
            k_q     <= 4'd1;
            state_q <= (state_q == S_SCAN_WIN) ? S_SCAN_BLK : S_PICK;
          end else begin
            k_q <= k_q + 4'd1;
          end
        end

        S_PICK: begin
          move_q       <= pick_d;
          no_move_q    <= (pick_d == '0);
          move_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end

        S_DONE: begin
          if (!move_valid_q) begin
            // Only reached from the bad-input path out of IDLE.
            move_q       <= '0;
            no_move_q    <= 1'b1;
            move_valid_q <= 1'b1;
          end else if (move_ready) begin
            move_valid_q <= 1'b0;
            no_move_q    <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign move       = move_q;
  assign move_valid = move_valid_q;
  assign no_move    = no_move_q;

endmodule

// File: tb/tb_tic_tac_toe_auto_player.sv
module tb_tic_tac_toe_auto_player;

  logic        clk;
  logic        rst;
  logic        req;
  logic [17:0] board;
  logic [1:0]  side;
  logic        busy;
  logic [3:0]  move;
  logic        move_valid;
  logic        move_ready;
  logic        no_move;

  int n_tests;
  int n_fail;

  tic_tac_toe_auto_player dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .board      (board),
    .side       (side),
    .busy       (busy),
    .move       (move),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .no_move    (no_move)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  // Board text: 9 chars for cells 1..9; 'X', 'O', '#' (illegal code), else empty.
  function automatic logic [17:0] bd(input string s);
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) begin
      case (s[i])
        "X":     b[2*i +: 2] = 2'b01;
        "O":     b[2*i +: 2] = 2'b10;
        "#":     b[2*i +: 2] = 2'b11;
        default: b[2*i +: 2] = 2'b00;
      endcase
    end
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle. Issues a request,
  // scrambles board/side after acceptance, measures the edge count to
  // move_valid, checks the result, then completes the handshake.
  task automatic run_vec(input string nm, input logic [17:0] b, input logic [1:0] sd,
                         input logic [3:0] exp_move, input logic exp_nm,
                         input int exp_lat, input logic hold_ready);
    int lat;
    board      = b;
    side       = sd;
    req        = 1'b1;
    move_ready = hold_ready;
    @(posedge clk); #1;
    req   = 1'b0;
    board = 18'($urandom);
    side  = 2'($urandom);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    lat = -1;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if (move_valid) begin
        lat = c;
        break;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_move"}, 32'(move), 32'(exp_move));
    chk({nm, "_no_move"}, 32'(no_move), 32'(exp_nm));
    move_ready = 1'b1;
    @(posedge clk); #1;
    move_ready = 1'b0;
    chk({nm, "_busy_released"}, 32'(busy), 32'd0);
    chk({nm, "_valid_cleared"}, 32'(move_valid), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    string      bs;
    logic [1:0] sd;
    logic [3:0] exp_move;
    logic       exp_nm;
    int         exp_lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int wait_n;
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{"win3",         "XX.OO....", 2'b01, 4'd3, 1'b0, 3};
    vecs[1]  = '{"block9",       "OX..O....", 2'b01, 4'd9, 1'b0, 18};
    vecs[2]  = '{"centre",       ".........", 2'b10, 4'd5, 1'b0, 19};
    vecs[3]  = '{"corner1",      "....X....", 2'b10, 4'd1, 1'b0, 19};
    vecs[4]  = '{"full",         "XOXXOOOXX", 2'b01, 4'd0, 1'b1, 19};
    vecs[5]  = '{"bad_side",     ".........", 2'b11, 4'd0, 1'b1, 1};
    vecs[6]  = '{"bad_cell",     "X...#....", 2'b01, 4'd0, 1'b1, 1};
    vecs[7]  = '{"win_over_blk", "XX.OO....", 2'b10, 4'd6, 1'b0, 6};
    vecs[8]  = '{"lowest_win",   "...XX...X", 2'b01, 4'd1, 1'b0, 1};
    vecs[9]  = '{"corner3",      "X...O....", 2'b01, 4'd3, 1'b0, 19};
    vecs[10] = '{"edge2",        "X.O.X.O.X", 2'b01, 4'd2, 1'b0, 19};

    // ---------------- reset ----------------
    rst        = 1'b1;
    req        = 1'b0;
    move_ready = 1'b0;
    board      = '0;
    side       = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_move", 32'(move), 32'd0);
    chk("reset_valid", 32'(move_valid), 32'd0);
    chk("reset_no_move", 32'(no_move), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ---------------- table ----------------
    // The block vector runs with move_ready held high through the scan.
    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i].name, bd(vecs[i].bs), vecs[i].sd, vecs[i].exp_move,
              vecs[i].exp_nm, vecs[i].exp_lat, (i == 1));
    end

    // ---------------- handshake hold + ignored req ----------------
    board = bd("XX.OO....");
    side  = 2'b01;
    req   = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    wait_n = 0;
    while (!move_valid && wait_n < 25) begin
      @(posedge clk); #1;
      wait_n++;
    end
    chk("hs_valid_seen", 32'(move_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      board = bd(".........");
      side  = 2'b10;
      req   = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      chk("hs_hold_move", 32'(move), 32'd3);
      chk("hs_hold_valid", 32'(move_valid), 32'd1);
      chk("hs_hold_busy", 32'(busy), 32'd1);
    end
    move_ready = 1'b1;
    @(posedge clk); #1;
    move_ready = 1'b0;
    chk("hs_busy_low", 32'(busy), 32'd0);
    chk("hs_valid_low", 32'(move_valid), 32'd0);
    @(posedge clk); #1;
    chk("hs_req_not_queued", 32'(busy), 32'd0);
    run_vec("hs_next", bd(".........."), 2'b10, 4'd5, 1'b0, 19, 1'b0);

    // ---------------- async reset mid SCAN_BLK ----------------
    board = bd("OX..O....");
    side  = 2'b01;
    req   = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_move", 32'(move), 32'd0);
    chk("rst_valid", 32'(move_valid), 32'd0);
    chk("rst_no_move", 32'(no_move), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_no_result", 32'(move_valid), 32'd0);
    run_vec("after_rst", bd("....X...."), 2'b10, 4'd1, 1'b0, 19, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
